// File: rtl/board_ram_arbiter_if.sv
// Signal bundle between the board RAM arbiter, its requesters and the RAM.
// The arbiter takes the slave view; requesters and the RAM take the master view.
interface board_ram_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4
);
  logic              init_hold;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic              pac_req;
  logic              pac_we;
  logic [ADDR_W-1:0] pac_addr;
  logic [DATA_W-1:0] pac_wdata;
  logic              pac_gnt;
  logic              pac_rvalid;
  logic              ghost_req;
  logic [ADDR_W-1:0] ghost_addr;
  logic              ghost_gnt;
  logic              ghost_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              board_ready;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  init_hold, init_addr, init_data,
    input  pac_req, pac_we, pac_addr, pac_wdata,
    input  ghost_req, ghost_addr,
    input  ram_rdata,
    output pac_gnt, pac_rvalid, ghost_gnt, ghost_rvalid, rdata, board_ready,
    output ram_addr, ram_wdata, ram_we
  );

  modport master (
    output init_hold, init_addr, init_data,
    output pac_req, pac_we, pac_addr, pac_wdata,
    output ghost_req, ghost_addr,
    output ram_rdata,
    input  pac_gnt, pac_rvalid, ghost_gnt, ghost_rvalid, rdata, board_ready,
    input  ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// Board RAM owner: initializer gets exclusive access, then pacman and ghost
// share the single port round-robin with a 1-cycle read return.
module board_ram_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 4,
  parameter int NUM_TILES = 768
) (
  input logic               clk,
  input logic               reset,
  board_ram_arbiter_if.slave bus
);
  typedef enum logic [0:0] {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] LAST_TILE = ADDR_W'(NUM_TILES - 1);

  function automatic logic tile_ok(input logic [ADDR_W-1:0] addr);
    return (addr <= LAST_TILE);
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic              hold_q_r;
  logic              rr_pac_r;
  logic              rr_pac_next_s;
  logic              pac_rd_r;
  logic              ghost_rd_r;
  logic              oor_r;
  logic              board_ready_r;
  logic [DATA_W-1:0] rdata_hold_r;
  logic [DATA_W-1:0] rdata_s;
  logic              pac_gnt_s;
  logic              ghost_gnt_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;

  // Next state, arbitration and RAM port steering.
  always_comb begin
    state_next_s  = state_r;
    rr_pac_next_s = rr_pac_r;
    pac_gnt_s     = 1'b0;
    ghost_gnt_s   = 1'b0;
    ram_addr_s    = '0;
    ram_wdata_s   = '0;
    ram_we_s      = 1'b0;
    case (state_r)
      S_INIT: begin
        ram_addr_s  = bus.init_addr;
        ram_wdata_s = bus.init_data;
        ram_we_s    = bus.init_hold & tile_ok(bus.init_addr);
        if (hold_q_r && !bus.init_hold) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_INIT;
        end
      end
      S_RUN: begin
        if (bus.init_hold) begin
          state_next_s = S_INIT;
        end else begin
          // The pointer only moves when both sides compete.
          if (bus.pac_req && bus.ghost_req) begin
            pac_gnt_s     = rr_pac_r;
            ghost_gnt_s   = ~rr_pac_r;
            rr_pac_next_s = ~rr_pac_r;
          end else begin
            pac_gnt_s   = bus.pac_req;
            ghost_gnt_s = bus.ghost_req;
          end
          if (pac_gnt_s) begin
            ram_addr_s  = bus.pac_addr;
            ram_wdata_s = bus.pac_wdata;
            ram_we_s    = bus.pac_we & tile_ok(bus.pac_addr);
          end else if (ghost_gnt_s) begin
            ram_addr_s  = bus.ghost_addr;
          end else begin
            ram_addr_s  = '0;
          end
        end
      end
      default: begin
        state_next_s = S_INIT;
      end
    endcase
  end

  // Read return data: live RAM data on the valid cycle, held value otherwise.
  always_comb begin
    if (pac_rd_r || ghost_rd_r) begin
      if (oor_r) begin
        rdata_s = '0;
      end else begin
        rdata_s = bus.ram_rdata;
      end
    end else begin
      rdata_s = rdata_hold_r;
    end
  end

  // State, round-robin pointer and read-return pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= S_INIT;
      hold_q_r      <= 1'b0;
      rr_pac_r      <= 1'b1;
      pac_rd_r      <= 1'b0;
      ghost_rd_r    <= 1'b0;
      oor_r         <= 1'b0;
      board_ready_r <= 1'b0;
      rdata_hold_r  <= '0;
    end else begin
      state_r       <= state_next_s;
      hold_q_r      <= bus.init_hold;
      rr_pac_r      <= rr_pac_next_s;
      pac_rd_r      <= pac_gnt_s & ~bus.pac_we;
      ghost_rd_r    <= ghost_gnt_s;
      oor_r         <= pac_gnt_s ? ~tile_ok(bus.pac_addr) : ~tile_ok(bus.ghost_addr);
      board_ready_r <= (state_next_s == S_RUN);
      rdata_hold_r  <= rdata_s;
    end
  end

  // The RAM port is forced idle while reset is asserted.
  assign bus.ram_addr     = {ADDR_W{reset}} & ram_addr_s;
  assign bus.ram_wdata    = {DATA_W{reset}} & ram_wdata_s;
  assign bus.ram_we       = reset & ram_we_s;
  assign bus.pac_gnt      = reset & pac_gnt_s;
  assign bus.ghost_gnt    = reset & ghost_gnt_s;
  assign bus.pac_rvalid   = pac_rd_r;
  assign bus.ghost_rvalid = ghost_rd_r;
  assign bus.rdata        = rdata_s;
  assign bus.board_ready  = board_ready_r;
endmodule
